if_fetch_unit: RTL and testbench
================================

IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, address of the first fetch after reset.
REQ-002 Port: clk  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  in  1  asynchronous, active-low reset (asserted when 0).
REQ-004 Port: stall_IF_ID  in  1  downstream hold; queue head is not consumed while 1.
REQ-005 Port: redirect_valid  in  1  taken branch/jump/exception redirect.
REQ-006 Port: redirect_target  in  32  new fetch address; bits [1:0] forced to 00.
REQ-007 Port: imem_req  out  1  instruction memory request.
REQ-008 Port: imem_addr  out  32  word-aligned request address.
REQ-009 Port: imem_ready  in  1  memory returns imem_rdata this cycle for the outstanding request.
REQ-010 Port: imem_rdata  in  32  returned instruction word.
REQ-011 Port: IF_Instruction  out  32  queue-head instruction; 32'b0 when queue empty.
REQ-012 Port: IF_PC  out  32  queue-head PC; 32'b0 when queue empty.
REQ-013 Port: IF_valid  out  1  queue non-empty.

Function
REQ-014 State: pc (32), req_addr (32), 2-entry FIFO of {instr, pc}, count (0..2), FSM state in {IDLE, WAIT, DRAIN}.
REQ-015 imem_req = (IDLE & count<2 & !redirect_valid) | WAIT | DRAIN; forced 0 while reset asserted.
REQ-016 imem_addr = pc in IDLE and WAIT; req_addr in DRAIN; req_addr loads pc on IDLE->WAIT.
REQ-017 Once imem_req rises it stays high with stable imem_addr until the cycle imem_ready=1.
REQ-018 imem_ready outside an active request is ignored.
REQ-019 IDLE, request, ready=1, no redirect: push {imem_rdata, pc}, pc <= pc+4, remain IDLE (zero-wait throughput 1 word/cycle).
REQ-020 IDLE, request, ready=0: -> WAIT.
REQ-021 WAIT, ready=1, no redirect: push {imem_rdata, pc}, pc <= pc+4, -> IDLE.
REQ-022 WAIT, redirect=1, ready=0: -> DRAIN; returned word is later discarded.
REQ-023 WAIT, redirect=1, ready=1: word discarded, -> IDLE.
REQ-024 DRAIN, ready=1: word discarded, -> IDLE; DRAIN, ready=0: stay.
REQ-025 Redirect in any state: FIFO flushed (count <= 0), pc <= {redirect_target[31:2],2'b00}; no push or pop that cycle.
REQ-026 Pop when count>0 & !stall_IF_ID & !redirect_valid; push and pop in the same cycle leave count unchanged and preserve order.
REQ-027 FIFO never overflows: request issued only with count<2, at most one request outstanding.
REQ-028 IF_* outputs combinational from FIFO head; latency from imem_ready to IF_valid is one cycle.
REQ-029 pc wraps 32'hFFFF_FFFC -> 32'h0000_0000 without flag.

Reset
REQ-030 Reset asserted: pc=RESET_PC, req_addr=0, count=0, state=IDLE, FIFO contents 0, IF_valid=0, IF_Instruction=0, IF_PC=0, imem_req=0.
REQ-031 Reset mid-request: outstanding request abandoned; late imem_ready after release while in IDLE with no request is ignored.
REQ-032 First request appears in the first cycle after reset deasserts, imem_addr=RESET_PC.

Verification
REQ-033 Zero-wait memory, stall=0: addresses 0,4,8,... issued each cycle; IF_PC 0,4,8 one cycle later with matching words.
REQ-034 stall_IF_ID=1 for 5 cycles, zero-wait: count reaches 2, imem_req drops, IF_PC holds 0x0; release -> 0x0,0x4,0x8 in order, none lost.
REQ-035 3-wait memory, redirect_target=0x0000_0103 during WAIT: DRAIN holds old addr until ready, word discarded, next request addr 0x0000_0100, IF_PC 0x100.
REQ-036 Redirect coincident with imem_ready in WAIT: that word never reaches IF_valid; next IF_PC = target.
REQ-037 Redirect with count=2 and stall=1: IF_valid=0 next cycle, FIFO empty, fetch resumes at target.
REQ-038 Reset pulsed low during WAIT: all outputs 0 immediately; after release imem_addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// ---------------------------------------------------------------------------
// if_fetch_unit
// Instruction fetch front end. It issues word-aligned requests to the
// instruction memory and keeps at most one request outstanding. Returned
// words go into a 2-entry {instr, pc} queue that the decode stage reads.
// A redirect flushes the queue and restarts fetch at the new target. If a
// request is still in flight when the redirect arrives, the unit waits for
// that word in DRAIN and then throws it away.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous reset, active low
//   stall_IF_ID      decode hold; the queue head is not consumed while high
//   redirect_valid   branch/jump/exception redirect this cycle
//   redirect_target  new fetch address (bits [1:0] ignored)
//   imem_req         instruction memory request
//   imem_addr        word-aligned request address
//   imem_ready       memory returns imem_rdata for the outstanding request
//   imem_rdata       returned instruction word
//   IF_Instruction   queue-head instruction (0 when empty)
//   IF_PC            queue-head pc (0 when empty)
//   IF_valid         queue non-empty
//
// state | meaning
// IDLE  | free to issue; the request completes this cycle if ready=1
// WAIT  | request at pc outstanding; the word will be kept
// DRAIN | request at req_addr outstanding after a redirect; the word is dropped
// ---------------------------------------------------------------------------
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall_IF_ID,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC,
    output logic        IF_valid
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [31:0] pc;
    logic [31:0] req_addr;
    logic [1:0]  count;
    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic [31:0] tail_instr;
    logic [31:0] tail_pc;

    logic        req_idle;
    logic        push;
    logic        pop;

    always_comb begin
        req_idle  = (state == S_IDLE) && (count != 2'd2) && !redirect_valid;
        // The reset term keeps the request low while the flops are held.
        // Without it, IDLE with an empty queue would request during reset.
        imem_req  = reset && (req_idle || (state == S_WAIT) || (state == S_DRAIN));
        imem_addr = (state == S_DRAIN) ? req_addr : pc;
        // A word is kept only when it answers a live request that was issued
        // before any redirect. This ignores stray ready pulses and drops
        // words that return in DRAIN.
        push      = imem_ready && !redirect_valid && (req_idle || (state == S_WAIT));
        pop       = (count != 2'd0) && !stall_IF_ID && !redirect_valid;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req_idle && !imem_ready) state_nxt = S_WAIT;
            S_WAIT: begin
                if (imem_ready)          state_nxt = S_IDLE;
                else if (redirect_valid) state_nxt = S_DRAIN;
            end
            S_DRAIN: if (imem_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            pc         <= RESET_PC & ~32'h3;
            req_addr   <= 32'h0;
            count      <= 2'd0;
            head_instr <= 32'h0;
            head_pc    <= 32'h0;
            tail_instr <= 32'h0;
            tail_pc    <= 32'h0;
        end else begin
            state <= state_nxt;

            // DRAIN has to keep presenting the old address after pc moves to
            // the redirect target, so the address is captured on IDLE->WAIT.
            if (state == S_IDLE && state_nxt == S_WAIT)
                req_addr <= pc;

            if (redirect_valid)
                pc <= redirect_target & ~32'h3;
            else if (push)
                pc <= pc + 32'd4;   // wraps through zero silently

            if (redirect_valid) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase

                // The head is kept in slot 0 so the outputs need no read mux.
                // A push writes the first free slot after any pop.
                if (push && pop) begin
                    if (count == 2'd1) begin
                        head_instr <= imem_rdata;
                        head_pc    <= pc;
                    end else begin
                        head_instr <= tail_instr;
                        head_pc    <= tail_pc;
                        tail_instr <= imem_rdata;
                        tail_pc    <= pc;
                    end
                end else if (push) begin
                    if (count == 2'd0) begin
                        head_instr <= imem_rdata;
                        head_pc    <= pc;
                    end else begin
                        tail_instr <= imem_rdata;
                        tail_pc    <= pc;
                    end
                end else if (pop) begin
                    head_instr <= tail_instr;
                    head_pc    <= tail_pc;
                end
            end
        end
    end

    always_comb begin
        IF_valid       = (count != 2'd0);
        IF_Instruction = IF_valid ? head_instr : 32'h0;
        IF_PC          = IF_valid ? head_pc    : 32'h0;
    end

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

    logic        clk;
    logic        reset;
    logic        stall_IF_ID;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;
    logic        IF_valid;

    int checks = 0;
    int errors = 0;
    int lat    = 0;
    int wcnt   = 0;
    logic        obs_req;
    logic [31:0] obs_addr;

    if_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk             (clk),
        .reset           (reset),
        .stall_IF_ID     (stall_IF_ID),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_ready      (imem_ready),
        .imem_rdata      (imem_rdata),
        .IF_Instruction  (IF_Instruction),
        .IF_PC           (IF_PC),
        .IF_valid        (IF_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return 32'hA500_0000 ^ a;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, obs, exp);
        end
    endtask

    // One clock cycle, entered and left on a falling edge. The memory model
    // answers a live request once it has waited lat cycles. force_rdy makes
    // it pulse ready even when nothing is requested.
    task automatic step(input logic st, input logic rv, input logic [31:0] rt,
                        input logic force_rdy);
        stall_IF_ID     = st;
        redirect_valid  = rv;
        redirect_target = rt;
        #1;
        obs_req  = imem_req;
        obs_addr = imem_addr;
        if (force_rdy || (imem_req && wcnt >= lat)) begin
            imem_ready = 1'b1;
            imem_rdata = word_of(imem_addr);
        end else begin
            imem_ready = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
        @(posedge clk);
        if (obs_req && !imem_ready) wcnt++;
        else                        wcnt = 0;
        @(negedge clk);
        imem_ready = 1'b0;
    endtask

    task automatic do_reset();
        stall_IF_ID    = 1'b0;
        redirect_valid = 1'b0;
        imem_ready     = 1'b0;
        reset          = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        wcnt  = 0;
    endtask

    initial begin
        reset           = 1'b0;
        stall_IF_ID     = 1'b0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        imem_ready      = 1'b0;
        imem_rdata      = 32'h0;
        #2;
        chk("rst_req",   {31'b0, imem_req}, 32'h0);
        chk("rst_valid", {31'b0, IF_valid}, 32'h0);
        chk("rst_pc",    IF_PC,             32'h0);
        chk("rst_instr", IF_Instruction,    32'h0);
        @(negedge clk);
        reset = 1'b1;

        // Zero-wait streaming
        lat = 0;
        step(0, 0, 0, 0);
        chk("zw_req0",  {31'b0, obs_req}, 32'h1);
        chk("zw_addr0", obs_addr, 32'h0);
        chk("zw_pc0",   IF_PC, 32'h0);
        chk("zw_ins0",  IF_Instruction, word_of(32'h0));
        step(0, 0, 0, 0);
        chk("zw_addr1", obs_addr, 32'h4);
        chk("zw_pc1",   IF_PC, 32'h4);
        step(0, 0, 0, 0);
        chk("zw_addr2", obs_addr, 32'h8);
        chk("zw_pc2",   IF_PC, 32'h8);
        chk("zw_ins2",  IF_Instruction, word_of(32'h8));

        // Stall fills the queue, then drains in order
        do_reset();
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0);
            if (i >= 2) chk("st_req_low", {31'b0, obs_req}, 32'h0);
        end
        chk("st_hold_pc", IF_PC, 32'h0);
        chk("st_valid",   {31'b0, IF_valid}, 32'h1);
        step(0, 0, 0, 0);
        chk("st_pc4", IF_PC, 32'h4);
        step(0, 0, 0, 0);
        chk("st_addr8", obs_addr, 32'h8);
        chk("st_pc8",   IF_PC, 32'h8);

        // 3-wait memory, redirect during WAIT -> DRAIN
        do_reset();
        lat = 3;
        step(0, 0, 0, 0);
        step(0, 1, 32'h0000_0103, 0);
        step(0, 0, 0, 0);
        chk("dr_hold_addr", obs_addr, 32'h0);
        chk("dr_hold_req",  {31'b0, obs_req}, 32'h1);
        step(0, 0, 0, 0);
        chk("dr_done_addr", obs_addr, 32'h0);
        chk("dr_discard",   {31'b0, IF_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("dr_new_addr", obs_addr, 32'h100);
        for (int i = 0; i < 10 && !IF_valid; i++) step(0, 0, 0, 0);
        chk("dr_pc",  IF_PC, 32'h100);
        chk("dr_ins", IF_Instruction, word_of(32'h100));

        // Redirect coincident with ready in WAIT
        do_reset();
        lat = 1;
        step(0, 0, 0, 0);
        step(0, 1, 32'h0000_0200, 0);
        chk("co_drop", {31'b0, IF_valid}, 32'h0);
        step(0, 0, 0, 0);
        chk("co_addr", obs_addr, 32'h200);
        step(0, 0, 0, 0);
        chk("co_pc",  IF_PC, 32'h200);
        chk("co_ins", IF_Instruction, word_of(32'h200));

        // Redirect with a full stalled queue, plus a stray ready
        do_reset();
        lat = 0;
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 1, 32'h0000_0300, 1);
        chk("fl_req", {31'b0, obs_req}, 32'h0);
        chk("fl_valid", {31'b0, IF_valid}, 32'h0);
        chk("fl_pc",    IF_PC, 32'h0);
        step(0, 0, 0, 0);
        chk("fl_addr",  obs_addr, 32'h300);
        chk("fl_pc2",   IF_PC, 32'h300);

        // Reset pulse during WAIT
        do_reset();
        lat = 3;
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        reset = 1'b0;
        #1;
        chk("rw_req",   {31'b0, imem_req}, 32'h0);
        chk("rw_addr",  imem_addr, 32'h0);
        chk("rw_valid", {31'b0, IF_valid}, 32'h0);
        chk("rw_pc",    IF_PC, 32'h0);
        chk("rw_ins",   IF_Instruction, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        wcnt  = 0;
        step(0, 0, 0, 0);
        chk("rw_req2",  {31'b0, obs_req}, 32'h1);
        chk("rw_addr2", obs_addr, 32'h0);

        // pc wrap at the top of the address space
        do_reset();
        lat = 0;
        step(0, 1, 32'hFFFF_FFFA, 0);
        step(0, 0, 0, 0);
        chk("wr_addr0", obs_addr, 32'hFFFF_FFF8);
        step(0, 0, 0, 0);
        chk("wr_addr1", obs_addr, 32'hFFFF_FFFC);
        chk("wr_pc1",   IF_PC, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("wr_addr2", obs_addr, 32'h0);
        chk("wr_pc2",   IF_PC, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
